// File: rtl/execute_multicycle_ctrl_pkg.sv
// Shared definitions for the execute-stage multi-cycle unit sequencer:
// default parameter values, the controller state enum and a helper for
// the unit-select width.
package execute_multicycle_ctrl_pkg;

    localparam int MCU_XLEN    = 32;
    localparam int MCU_NUNIT   = 2;
    localparam int MCU_OP_W    = 4;
    localparam int MCU_TIMEOUT = 64;
    localparam int MCU_WADDR_W = 5;

    typedef enum logic [2:0] {
        MCU_IDLE  = 3'd0,
        MCU_ISSUE = 3'd1,
        MCU_WAIT  = 3'd2,
        MCU_DONE  = 3'd3,
        MCU_FLUSH = 3'd4
    } mcu_state_type;

    // A single unit still needs a one-bit select field.
    function automatic int mcu_usel_w(input int nunit);
        return (nunit > 1) ? $clog2(nunit) : 1;
    endfunction

endpackage

// File: rtl/execute_multicycle_ctrl_watchdog.sv
// Watchdog timer for the multi-cycle sequencer.
// Ports:
//   clk_i, rst_ni  clock / asynchronous active-low reset
//   clear_i        reload the timer (op is being issued)
//   count_en_i     sequencer is waiting on the unit this cycle
//   expired_o      this waiting cycle is the last one allowed
// The timer counts down the remaining waiting cycles: it is loaded with
// TIMEOUT-1 and the terminal count of zero marks the final allowed cycle,
// i.e. the TIMEOUT-th waiting cycle since the issue.
module execute_multicycle_ctrl_watchdog
    import execute_multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = MCU_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = CNT_LOAD;
        end else if (count_en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_en_i && (cnt_q == '0);

endmodule

// File: rtl/execute_multicycle_ctrl.sv
// Execute-stage sequencer for NUNIT multi-cycle functional units.
// Latches one issued op, pulses the target unit's enable, stalls the
// pipeline until the unit reports ready, then presents one writeback.
// A kill drains an in-flight op and discards its result; a watchdog
// aborts a unit that never answers.
// Ports:
//   clk_i, rst_ni                 clock / asynchronous active-low reset
//   issue_*_i                     op request: valid, unit, op, waddr, operands
//   kill_i                        pipeline flush
//   hold_i                        downstream stall, freezes a finished result
//   fu_enable_o                   one-hot start pulse to the units
//   fu_op_o, fu_rdata1/2_o        latched op and operands to all units
//   fu_ready_i, fu_result_i       per-unit ready and result slices
//   stall_o                       execute stage must hold
//   wb_valid/wren/waddr/wdata_o   writeback
//   timeout_o                     one-cycle pulse on watchdog abort
//
// state     | meaning
// ----------+------------------------------------------------------------
// MCU_IDLE  | no op in flight, accepting issues
// MCU_ISSUE | enable pulse to the selected unit, watchdog reloaded
// MCU_WAIT  | waiting for the selected unit's ready
// MCU_DONE  | result presented on writeback, held while hold_i
// MCU_FLUSH | killed op still running in the unit, result to be dropped
module execute_multicycle_ctrl
    import execute_multicycle_ctrl_pkg::*;
#(
    parameter int XLEN    = MCU_XLEN,
    parameter int NUNIT   = MCU_NUNIT,
    parameter int OP_W    = MCU_OP_W,
    parameter int TIMEOUT = MCU_TIMEOUT,
    parameter int USEL_W  = mcu_usel_w(NUNIT)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   issue_valid_i,
    input  logic [USEL_W-1:0]      issue_unit_i,
    input  logic [OP_W-1:0]        issue_op_i,
    input  logic [4:0]             issue_waddr_i,
    input  logic [XLEN-1:0]        issue_rdata1_i,
    input  logic [XLEN-1:0]        issue_rdata2_i,
    input  logic                   kill_i,
    input  logic                   hold_i,
    output logic [NUNIT-1:0]       fu_enable_o,
    output logic [OP_W-1:0]        fu_op_o,
    output logic [XLEN-1:0]        fu_rdata1_o,
    output logic [XLEN-1:0]        fu_rdata2_o,
    input  logic [NUNIT-1:0]       fu_ready_i,
    input  logic [NUNIT*XLEN-1:0]  fu_result_i,
    output logic                   stall_o,
    output logic                   wb_valid_o,
    output logic                   wb_wren_o,
    output logic [4:0]             wb_waddr_o,
    output logic [XLEN-1:0]        wb_wdata_o,
    output logic                   timeout_o
);

    typedef struct packed {
        logic                   valid;
        logic [USEL_W-1:0]      unit;
        logic [OP_W-1:0]        op;
        logic [MCU_WADDR_W-1:0] waddr;
        logic [XLEN-1:0]        rdata1;
        logic [XLEN-1:0]        rdata2;
    } mcu_issue_type;

    typedef struct packed {
        logic                   valid;
        logic                   wren;
        logic [MCU_WADDR_W-1:0] waddr;
        logic [XLEN-1:0]        wdata;
    } mcu_wb_type;

    typedef struct packed {
        logic [USEL_W-1:0]      unit;
        logic [OP_W-1:0]        op;
        logic [MCU_WADDR_W-1:0] waddr;
        logic [XLEN-1:0]        rdata1;
        logic [XLEN-1:0]        rdata2;
        logic [XLEN-1:0]        result;
        logic                   timeout;
    } mcu_reg_type;

    localparam mcu_reg_type init_mcu_reg = '0;

    mcu_state_type state_q;
    mcu_state_type state_d;
    mcu_reg_type   reg_q;
    mcu_reg_type   reg_d;
    mcu_issue_type issue_w;
    mcu_wb_type    wb_w;

    logic            accept;
    logic            load_op;
    logic            sel_ready;
    logic [XLEN-1:0] sel_result;
    logic            wdog_clear;
    logic            wdog_en;
    logic            wdog_expired;

    assign issue_w = '{valid:  issue_valid_i,
                       unit:   issue_unit_i,
                       op:     issue_op_i,
                       waddr:  issue_waddr_i,
                       rdata1: issue_rdata1_i,
                       rdata2: issue_rdata2_i};

    // Out-of-range unit indices are dropped without stalling the pipe.
    assign accept = issue_w.valid && !kill_i && (int'(issue_w.unit) < NUNIT);

    // Only the latched unit's ready/result matter; the others are ignored.
    always_comb begin
        sel_ready  = 1'b0;
        sel_result = '0;
        for (int u = 0; u < NUNIT; u++) begin
            if (int'(reg_q.unit) == u) begin
                sel_ready  = fu_ready_i[u];
                sel_result = fu_result_i[u*XLEN +: XLEN];
            end
        end
    end

    assign wdog_clear = (state_q == MCU_ISSUE);
    assign wdog_en    = (state_q == MCU_WAIT) || (state_q == MCU_FLUSH);

    execute_multicycle_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (wdog_clear),
        .count_en_i (wdog_en),
        .expired_o  (wdog_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MCU_IDLE;
            reg_q   <= init_mcu_reg;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        reg_d         = reg_q;
        reg_d.timeout = 1'b0;
        load_op       = 1'b0;
        case (state_q)
            MCU_IDLE: begin
                if (accept) begin
                    state_d = MCU_ISSUE;
                    load_op = 1'b1;
                end
            end
            MCU_ISSUE: begin
                state_d = kill_i ? MCU_FLUSH : MCU_WAIT;
            end
            MCU_WAIT: begin
                // Ready beats the watchdog; a kill alongside ready just drops the result.
                if (sel_ready) begin
                    if (kill_i) begin
                        state_d = MCU_IDLE;
                    end else begin
                        state_d      = MCU_DONE;
                        reg_d.result = sel_result;
                    end
                end else if (wdog_expired) begin
                    state_d       = MCU_IDLE;
                    reg_d.timeout = 1'b1;
                end else if (kill_i) begin
                    state_d = MCU_FLUSH;
                end
            end
            MCU_DONE: begin
                if (kill_i) begin
                    state_d = MCU_IDLE;
                end else if (!hold_i) begin
                    if (accept) begin
                        state_d = MCU_ISSUE;
                        load_op = 1'b1;
                    end else begin
                        state_d = MCU_IDLE;
                    end
                end
            end
            MCU_FLUSH: begin
                if (sel_ready) begin
                    state_d = MCU_IDLE;
                end else if (wdog_expired) begin
                    state_d       = MCU_IDLE;
                    reg_d.timeout = 1'b1;
                end
            end
            default: begin
                state_d = MCU_IDLE;
            end
        endcase
        if (load_op) begin
            reg_d.unit   = issue_w.unit;
            reg_d.op     = issue_w.op;
            reg_d.waddr  = issue_w.waddr;
            reg_d.rdata1 = issue_w.rdata1;
            reg_d.rdata2 = issue_w.rdata2;
        end
    end

    always_comb begin
        fu_enable_o = '0;
        stall_o     = 1'b0;
        wb_w        = '0;
        case (state_q)
            MCU_IDLE: begin
                stall_o = accept;
            end
            MCU_ISSUE: begin
                stall_o = 1'b1;
                for (int u = 0; u < NUNIT; u++) begin
                    fu_enable_o[u] = (int'(reg_q.unit) == u);
                end
            end
            MCU_WAIT: begin
                stall_o = 1'b1;
            end
            MCU_DONE: begin
                // kill must suppress the writeback in the same cycle.
                wb_w.valid = !kill_i;
                wb_w.wren  = !kill_i && (reg_q.waddr != '0);
                wb_w.waddr = kill_i ? '0 : reg_q.waddr;
                wb_w.wdata = kill_i ? '0 : reg_q.result;
            end
            MCU_FLUSH: begin
                stall_o = issue_valid_i;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    assign fu_op_o     = reg_q.op;
    assign fu_rdata1_o = reg_q.rdata1;
    assign fu_rdata2_o = reg_q.rdata2;
    assign wb_valid_o  = wb_w.valid;
    assign wb_wren_o   = wb_w.wren;
    assign wb_waddr_o  = wb_w.waddr;
    assign wb_wdata_o  = wb_w.wdata;
    assign timeout_o   = reg_q.timeout;

endmodule

// File: tb/tb_execute_multicycle_ctrl.sv
module tb_execute_multicycle_ctrl;

    localparam int XLEN   = 32;
    localparam int NUNIT  = 3;
    localparam int OP_W   = 4;
    localparam int TO     = 8;
    localparam int USEL_W = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  issue_valid_i;
    logic [USEL_W-1:0]     issue_unit_i;
    logic [OP_W-1:0]       issue_op_i;
    logic [4:0]            issue_waddr_i;
    logic [XLEN-1:0]       issue_rdata1_i;
    logic [XLEN-1:0]       issue_rdata2_i;
    logic                  kill_i;
    logic                  hold_i;
    logic [NUNIT-1:0]      fu_enable_o;
    logic [OP_W-1:0]       fu_op_o;
    logic [XLEN-1:0]       fu_rdata1_o;
    logic [XLEN-1:0]       fu_rdata2_o;
    logic [NUNIT-1:0]      fu_ready_i;
    logic [NUNIT*XLEN-1:0] fu_result_i;
    logic                  stall_o;
    logic                  wb_valid_o;
    logic                  wb_wren_o;
    logic [4:0]            wb_waddr_o;
    logic [XLEN-1:0]       wb_wdata_o;
    logic                  timeout_o;

    execute_multicycle_ctrl #(
        .XLEN    (XLEN),
        .NUNIT   (NUNIT),
        .OP_W    (OP_W),
        .TIMEOUT (TO),
        .USEL_W  (USEL_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid_i),
        .issue_unit_i   (issue_unit_i),
        .issue_op_i     (issue_op_i),
        .issue_waddr_i  (issue_waddr_i),
        .issue_rdata1_i (issue_rdata1_i),
        .issue_rdata2_i (issue_rdata2_i),
        .kill_i         (kill_i),
        .hold_i         (hold_i),
        .fu_enable_o    (fu_enable_o),
        .fu_op_o        (fu_op_o),
        .fu_rdata1_o    (fu_rdata1_o),
        .fu_rdata2_o    (fu_rdata2_o),
        .fu_ready_i     (fu_ready_i),
        .fu_result_i    (fu_result_i),
        .stall_o        (stall_o),
        .wb_valid_o     (wb_valid_o),
        .wb_wren_o      (wb_wren_o),
        .wb_waddr_o     (wb_waddr_o),
        .wb_wdata_o     (wb_wdata_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int sched [NUNIT];

    // Reference model: one outstanding transaction described by flags.
    bit          m_busy, m_fresh, m_killed, m_have, m_tpulse;
    int          m_wait, m_unit;
    logic [3:0]  m_op;
    logic [4:0]  m_waddr;
    logic [31:0] m_a, m_b, m_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_fresh = 0; m_killed = 0; m_have = 0; m_tpulse = 0;
        m_wait = 0; m_unit = 0;
        m_op = '0; m_waddr = '0; m_a = '0; m_b = '0; m_res = '0;
    endtask

    task automatic zero_inputs();
        issue_valid_i = 0; issue_unit_i = '0; issue_op_i = '0; issue_waddr_i = '0;
        issue_rdata1_i = '0; issue_rdata2_i = '0; kill_i = 0; hold_i = 0;
        fu_ready_i = '0; fu_result_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enable"}, 64'(fu_enable_o), 64'd0);
        chk({tag, "_op"},     64'(fu_op_o), 64'd0);
        chk({tag, "_rd1"},    64'(fu_rdata1_o), 64'd0);
        chk({tag, "_rd2"},    64'(fu_rdata2_o), 64'd0);
        chk({tag, "_stall"},  64'(stall_o), 64'd0);
        chk({tag, "_wbv"},    64'(wb_valid_o), 64'd0);
        chk({tag, "_wren"},   64'(wb_wren_o), 64'd0);
        chk({tag, "_waddr"},  64'(wb_waddr_o), 64'd0);
        chk({tag, "_wdata"},  64'(wb_wdata_o), 64'd0);
        chk({tag, "_tmo"},    64'(timeout_o), 64'd0);
    endtask

    function automatic bit can_take();
        return issue_valid_i && !kill_i && (int'(issue_unit_i) < NUNIT);
    endfunction

    task automatic check_cycle();
        bit          wbv, st;
        logic [2:0]  en;
        en  = m_fresh ? 3'(1 << m_unit) : 3'd0;
        wbv = m_have && !kill_i;
        st  = (!m_busy && can_take()) || m_fresh ||
              (m_busy && !m_fresh && !m_have && !m_killed) ||
              (m_killed && issue_valid_i);
        chk("enable", 64'(fu_enable_o), 64'(en));
        chk("stall",  64'(stall_o), 64'(st));
        chk("wbv",    64'(wb_valid_o), 64'(wbv));
        chk("wren",   64'(wb_wren_o), 64'(wbv && (m_waddr != 0)));
        chk("waddr",  64'(wb_waddr_o), wbv ? 64'(m_waddr) : 64'd0);
        chk("wdata",  64'(wb_wdata_o), wbv ? 64'(m_res) : 64'd0);
        chk("tmo",    64'(timeout_o), 64'(m_tpulse));
        chk("fu_op",  64'(fu_op_o), 64'(m_op));
        chk("fu_rd1", 64'(fu_rdata1_o), 64'(m_a));
        chk("fu_rd2", 64'(fu_rdata2_o), 64'(m_b));
    endtask

    task automatic latch_issue();
        m_busy = 1; m_fresh = 1; m_killed = 0;
        m_unit = int'(issue_unit_i);
        m_op = issue_op_i; m_waddr = issue_waddr_i;
        m_a = issue_rdata1_i; m_b = issue_rdata2_i;
    endtask

    // Advance the model across one rising edge using the inputs just applied.
    task automatic step_model();
        bit rdy, waiting, expire;
        rdy     = fu_ready_i[m_unit];
        waiting = m_busy && !m_fresh && !m_have;
        expire  = waiting && !rdy && (m_wait == TO - 1);
        m_tpulse = expire;
        if (!m_busy) begin
            if (can_take()) latch_issue();
        end else if (m_fresh) begin
            m_fresh = 0; m_wait = 0; m_killed = kill_i;
        end else if (m_have) begin
            if (kill_i) begin
                m_busy = 0; m_have = 0;
            end else if (!hold_i) begin
                m_have = 0;
                if (can_take()) latch_issue();
                else m_busy = 0;
            end
        end else begin
            if (rdy) begin
                if (m_killed || kill_i) begin
                    m_busy = 0; m_killed = 0;
                end else begin
                    m_have = 1;
                    m_res  = fu_result_i[m_unit*XLEN +: XLEN];
                end
            end else if (expire) begin
                m_busy = 0; m_killed = 0;
            end else begin
                if (kill_i) m_killed = 1;
                m_wait++;
            end
        end
    endtask

    task automatic one_cycle();
        @(negedge clk_i);
        // Units answer 1..10 cycles after the enable; 9 and 10 overrun the watchdog.
        if (m_fresh) sched[m_unit] = cyc + $urandom_range(1, 10);
        issue_valid_i  = ($urandom_range(0, 1) == 1);
        issue_unit_i   = USEL_W'($urandom_range(0, 3));
        issue_op_i     = OP_W'($urandom);
        issue_waddr_i  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        issue_rdata1_i = $urandom;
        issue_rdata2_i = $urandom;
        kill_i         = ($urandom_range(0, 11) == 0);
        hold_i         = ($urandom_range(0, 2) == 0);
        for (int u = 0; u < NUNIT; u++) begin
            fu_ready_i[u] = (sched[u] == cyc) ||
                            (!(m_busy && u == m_unit) && ($urandom_range(0, 3) == 0));
            fu_result_i[u*XLEN +: XLEN] = $urandom;
        end
        #1;
        check_cycle();
        @(posedge clk_i);
        step_model();
        cyc++;
    endtask

    task automatic mid_op_reset();
        @(negedge clk_i);
        #2;
        rst_ni = 0;
        zero_inputs();
        #1;
        check_all_zero("rst_mid");
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    initial begin
        for (int u = 0; u < NUNIT; u++) sched[u] = -1;
        rst_ni = 0;
        zero_inputs();
        model_reset();
        #1;
        check_all_zero("rst_por");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;

        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                // Try to land the reset while an op is waiting on its unit.
                for (int k = 0; k < 50 && !(m_busy && !m_fresh && !m_have); k++) one_cycle();
                mid_op_reset();
            end
            one_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
